// File: rtl/pipelined_divider_if.sv
// Valid/ready bundle between a divider and its source/sink.
// DIV_ZERO_FLAG_EN adds the div_by_zero sideband.
interface pipelined_divider_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic         div_by_zero;
`endif

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
`ifdef DIV_ZERO_FLAG_EN
    output div_by_zero,
`endif
    output remainder
  );

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
`ifdef DIV_ZERO_FLAG_EN
    input  div_by_zero,
`endif
    input  remainder
  );
endinterface

// File: rtl/pipelined_divider.sv
// N-stage unsigned restoring divider, one quotient bit per stage.
// Optional DIV_ZERO_FLAG_EN pipes a divide-by-zero flag with each beat.
module pipelined_divider #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             reset,
  pipelined_divider_if.slave bus
);

  logic         w_stall;

  logic         r_vld [1:N];
  logic [N-1:0] r_rem [1:N];
  logic [N-1:0] r_quo [1:N];
  logic [N-1:0] r_dvd [1:N-1];
  logic [N-1:0] r_dvs [1:N-1];

  logic         w_s_vld [0:N-1];
  logic [N-1:0] w_s_rem [0:N-1];
  logic [N-1:0] w_s_quo [0:N-1];
  logic [N-1:0] w_s_dvd [0:N-1];
  logic [N-1:0] w_s_dvs [0:N-1];

  logic         w_n_vld [1:N];
  logic [N-1:0] w_n_rem [1:N];
  logic [N-1:0] w_n_quo [1:N];
  logic [N-1:0] w_n_dvd [1:N-1];
  logic [N-1:0] w_n_dvs [1:N-1];

  logic [N:0]   w_rp [1:N];
  logic [N-1:0] w_df [1:N];
  logic         w_ge [1:N];

`ifdef DIV_ZERO_FLAG_EN
  logic         r_dz   [1:N];
  logic         w_s_dz [0:N-1];
  logic         w_n_dz [1:N];
`endif

  assign w_stall      = r_vld[N] & ~bus.out_ready;
  assign bus.in_ready = ~w_stall;

  // stage 0 is the input port; stages 1..N-1 feed the next stage
  always_comb begin
    w_s_vld[0] = bus.in_valid;
    w_s_rem[0] = '0;
    w_s_quo[0] = '0;
    w_s_dvd[0] = bus.dividend;
    w_s_dvs[0] = bus.divisor;
    for (int k = 1; k < N; k++) begin
      w_s_vld[k] = r_vld[k];
      w_s_rem[k] = r_rem[k];
      w_s_quo[k] = r_quo[k];
      w_s_dvd[k] = r_dvd[k];
      w_s_dvs[k] = r_dvs[k];
    end
  end

  always_comb begin
    for (int k = 1; k <= N; k++) begin
      w_rp[k] = {w_s_rem[k-1], w_s_dvd[k-1][N-1]};
      w_ge[k] = w_rp[k] >= {1'b0, w_s_dvs[k-1]};
      // true difference is < 2^N, so N-bit wrap is exact
      w_df[k] = w_rp[k][N-1:0] - w_s_dvs[k-1];
      w_n_vld[k] = w_s_vld[k-1];
      w_n_rem[k] = '0;
      w_n_quo[k] = '0;
      if (w_s_vld[k-1]) begin
        w_n_rem[k] = w_ge[k] ? w_df[k] : w_rp[k][N-1:0];
        w_n_quo[k] = {w_s_quo[k-1][N-2:0], w_ge[k]};
      end
    end
    for (int k = 1; k < N; k++) begin
      w_n_dvd[k] = '0;
      w_n_dvs[k] = '0;
      if (w_s_vld[k-1]) begin
        w_n_dvd[k] = {w_s_dvd[k-1][N-2:0], 1'b0};
        w_n_dvs[k] = w_s_dvs[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= N; k++) begin
        r_vld[k] <= 1'b0;
        r_rem[k] <= '0;
        r_quo[k] <= '0;
      end
      for (int k = 1; k < N; k++) begin
        r_dvd[k] <= '0;
        r_dvs[k] <= '0;
      end
    end else if (!w_stall) begin
      for (int k = 1; k <= N; k++) begin
        r_vld[k] <= w_n_vld[k];
        r_rem[k] <= w_n_rem[k];
        r_quo[k] <= w_n_quo[k];
      end
      for (int k = 1; k < N; k++) begin
        r_dvd[k] <= w_n_dvd[k];
        r_dvs[k] <= w_n_dvs[k];
      end
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  always_comb begin
    w_s_dz[0] = (bus.divisor == '0);
    for (int k = 1; k < N; k++) begin
      w_s_dz[k] = r_dz[k];
    end
    for (int k = 1; k <= N; k++) begin
      w_n_dz[k] = w_s_vld[k-1] & w_s_dz[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= N; k++) begin
        r_dz[k] <= 1'b0;
      end
    end else if (!w_stall) begin
      for (int k = 1; k <= N; k++) begin
        r_dz[k] <= w_n_dz[k];
      end
    end
  end

  assign bus.div_by_zero = r_dz[N];
`endif

  assign bus.out_valid = r_vld[N];
  assign bus.quotient  = r_quo[N];
  assign bus.remainder = r_rem[N];

endmodule
